// File: rtl/digit_glyph_pkg.sv
// Shared constants, types and stroke geometry for the digit glyph renderer.
// Seven-segment masks are indexed by BCD code; bit n corresponds to seg_e value n.
package digit_glyph_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    typedef logic [5:0] color_t;
    typedef logic [6:0] seg_mask_t;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_e;

    // Codes 10-15 carry no strokes and render as background.
    localparam seg_mask_t SEG_MASK [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00,
        7'h00, 7'h00, 7'h00, 7'h00
    };

    // True when cell coordinate (col,row) lies on a lit stroke of mask m.
    function automatic logic seg_lit(
        input seg_mask_t  m,
        input logic [2:0] col,
        input logic [3:0] row
    );
        logic in_cols;
        logic up_rows;
        logic lo_rows;
        in_cols = (col >= 3'd1) && (col <= 3'd6);
        up_rows = (row >= 4'd1) && (row <= 4'd8);
        lo_rows = (row >= 4'd7) && (row <= 4'd14);
        seg_lit = (m[SEG_A] && row == 4'd1 && in_cols)
               || (m[SEG_B] && col == 3'd6 && up_rows)
               || (m[SEG_C] && col == 3'd6 && lo_rows)
               || (m[SEG_D] && row == 4'd14 && in_cols)
               || (m[SEG_E] && col == 3'd1 && lo_rows)
               || (m[SEG_F] && col == 3'd1 && up_rows)
               || (m[SEG_G] && (row == 4'd7 || row == 4'd8) && in_cols);
    endfunction

endpackage

// File: rtl/digit_glyph_renderer_glyph_rom.sv
// Second pipeline stage: registered lookup of a glyph cell pixel.
// Out-of-box pixels arrive with en_i low and always miss.
module glyph_rom
    import digit_glyph_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic [2:0] col_i,
    input  logic [3:0] row_i,
    input  logic [3:0] code_i,
    output logic       hit_o
);

    logic hit_q;
    logic hit_d;

    // Stroke test for the requested code at this cell coordinate.
    always_comb begin
        hit_d = en_i && seg_lit(SEG_MASK[code_i], col_i, row_i);
    end

    // Register the hit bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/digit_glyph_renderer.sv
// Raster-position to pixel-color renderer for a row of decimal digits.
// Three stages: cell position/code, glyph hit, output color.
module digit_glyph_renderer
    import digit_glyph_pkg::*;
#(
    parameter int     NUM_DIGITS    = 3,
    parameter int     SCALE_LOG2    = 1,
    parameter int     ORIGIN_X      = 64,
    parameter int     ORIGIN_Y      = 48,
    parameter color_t FG_COLOR      = 6'b000000,
    parameter color_t BG_COLOR      = 6'b111111,
    parameter bit     BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    input  logic                    pix_valid,
    input  logic                    frame_start,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    digits_load,
    output logic [5:0]              data,
    output logic                    data_valid
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CELL_W = GLYPH_W << SCALE_LOG2;
    localparam int BOX_W = NUM_DIGITS * CELL_W;
    localparam int BOX_H = GLYPH_H << SCALE_LOG2;

    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] active_q, active_d;

    // Two's complement offsets; bit 10 set means left of / above the box.
    logic [10:0] rel_x;
    logic [10:0] rel_y;
    logic [10:0] idx_full;
    logic        in_box_d;

    logic        zrun;
    logic [3:0]  dig;
    logic [3:0]  code_arr [NUM_DIGITS];
    logic [3:0]  code_d;

    logic [2:0]  col_q;
    logic [3:0]  row_q;
    logic [3:0]  code_q;
    logic        in_box_q;
    logic        hit;
    color_t      data_q, data_d;
    logic [2:0]  vld_q;

    // Shadow takes host writes; active follows shadow once per frame.
    always_comb begin
        shadow_d = digits_load ? digits_in : shadow_q;
        active_d = frame_start ? shadow_q : active_q;
    end

    // Double-buffered digit registers, reset to all-blank codes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= {NUM_DIGITS{4'hF}};
            active_q <= {NUM_DIGITS{4'hF}};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign rel_x    = 11'({1'b0, hcount}) - 11'(ORIGIN_X);
    assign rel_y    = 11'({1'b0, vcount}) - 11'(ORIGIN_Y);
    assign idx_full = rel_x >> (3 + SCALE_LOG2);
    assign in_box_d = !rel_x[10] && !rel_y[10]
                   && (rel_x < 11'(BOX_W))
                   && (rel_y < 11'(BOX_H));

    // Effective code per digit with leading zeros replaced by blank.
    always_comb begin
        zrun = 1'b1;
        dig  = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            code_arr[i] = 4'hF;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig  = active_q[4*(NUM_DIGITS-1-i) +: 4];
            zrun = zrun && (dig == 4'd0);
            if (BLANK_LEADING && zrun && (i != NUM_DIGITS - 1)) begin
                code_arr[i] = 4'hF;
            end else begin
                code_arr[i] = dig;
            end
        end
    end

    // Pick the code of the digit cell under the current column.
    always_comb begin
        code_d = 4'hF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_full == 11'(i)) begin
                code_d = code_arr[i];
            end
        end
    end

    // S1: cell coordinates, digit code and in-box flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q    <= 3'd0;
            row_q    <= 4'd0;
            code_q   <= 4'd0;
            in_box_q <= 1'b0;
        end else begin
            col_q    <= rel_x[SCALE_LOG2 +: 3];
            row_q    <= rel_y[SCALE_LOG2 +: 4];
            code_q   <= code_d;
            in_box_q <= in_box_d;
        end
    end

    // S2: glyph hit bit.
    glyph_rom u_rom (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (in_box_q),
        .col_i   (col_q),
        .row_i   (row_q),
        .code_i  (code_q),
        .hit_o   (hit)
    );

    // Color select for the output stage.
    always_comb begin
        data_d = hit ? FG_COLOR : BG_COLOR;
    end

    // S3: output color and the valid delay line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= BG_COLOR;
            vld_q  <= 3'b000;
        end else begin
            data_q <= data_d;
            vld_q  <= {vld_q[1:0], pix_valid};
        end
    end

    assign data       = data_q;
    assign data_valid = vld_q[2];

endmodule

// File: tb/tb_digit_glyph_renderer.sv
// Bench for digit_glyph_renderer: directed vectors, corner sequences,
// and randomized raster traffic against a behavioural pixel model.
module tb_digit_glyph_renderer;

    localparam logic [5:0] FG = 6'b000000;
    localparam logic [5:0] BG = 6'b111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic        pix_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [11:0] digits_in = '0;
    logic        digits_load = 1'b0;
    logic [5:0]  data0, data1, data2;
    logic        dv0, dv1, dv2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    digit_glyph_renderer u_def (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .digits_in(digits_in), .digits_load(digits_load),
        .data(data0), .data_valid(dv0)
    );

    digit_glyph_renderer #(.SCALE_LOG2(0), .BLANK_LEADING(1'b0)) u_s0 (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .digits_in(digits_in), .digits_load(digits_load),
        .data(data1), .data_valid(dv1)
    );

    digit_glyph_renderer #(.SCALE_LOG2(2), .BLANK_LEADING(1'b1)) u_s2 (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .digits_in(digits_in), .digits_load(digits_load),
        .data(data2), .data_valid(dv2)
    );

    string SEGS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg",
                         "", "", "", "", "", ""};

    function automatic bit on_stroke(byte s, int c, int r);
        bit hc = (c >= 1 && c <= 6);
        if (s == "a") return r == 1 && hc;
        if (s == "b") return c == 6 && r >= 1 && r <= 8;
        if (s == "c") return c == 6 && r >= 7 && r <= 14;
        if (s == "d") return r == 14 && hc;
        if (s == "e") return c == 1 && r >= 7 && r <= 14;
        if (s == "f") return c == 1 && r >= 1 && r <= 8;
        if (s == "g") return (r == 7 || r == 8) && hc;
        return 1'b0;
    endfunction

    // Pixel color for a 3-digit display at origin (64,48).
    function automatic logic [5:0] model(int x, int y, logic [11:0] dg,
                                         int s, bit bl);
        int cw, ch, rx, ry, di, c, r, v;
        bit allz;
        string segs;
        cw = 8 << s;
        ch = 16 << s;
        rx = x - 64;
        ry = y - 48;
        if (rx < 0 || ry < 0 || rx >= 3 * cw || ry >= ch) return BG;
        di = rx / cw;
        c = (rx % cw) / (1 << s);
        r = ry / (1 << s);
        v = int'((dg >> (4 * (2 - di))) & 12'hF);
        allz = 1'b1;
        for (int k = 0; k <= di; k++) begin
            if (((dg >> (4 * (2 - k))) & 12'hF) != 0) allz = 1'b0;
        end
        if (bl && allz && di != 2) return BG;
        segs = SEGS[v];
        for (int i = 0; i < segs.len(); i++) begin
            if (on_stroke(segs[i], c, r)) return FG;
        end
        return BG;
    endfunction

    function automatic bit legacy4(int c, int r);
        return (c == 1 && r >= 1 && r <= 8)
            || (c == 6 && r >= 1 && r <= 14)
            || (r >= 7 && r <= 8 && c >= 1 && c <= 6);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [11:0] d, bit fs_same);
        digits_in = d;
        digits_load = 1'b1;
        frame_start = fs_same;
        tick();
        digits_load = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Hold one pixel long enough for it to reach the output.
    task automatic probe(int x, int y);
        hcount = 10'(x);
        vcount = 10'(y);
        pix_valid = 1'b1;
        repeat (3) tick();
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [5:0] exp;
        string      nm;
    } vec_t;

    typedef struct {
        logic [5:0] e0;
        logic [5:0] e1;
        logic [5:0] e2;
        logic       v;
    } exp_t;

    exp_t        q[$];
    logic [11:0] sh_m;
    logic [11:0] act_m;

    // One streaming cycle; compares the pixel issued two calls earlier.
    task automatic apply(int x, int y, bit v, bit ld, logic [11:0] d, bit fs);
        exp_t e;
        logic [11:0] nact;
        hcount = 10'(x);
        vcount = 10'(y);
        pix_valid = v;
        digits_load = ld;
        digits_in = d;
        frame_start = fs;
        e.e0 = model(x, y, act_m, 1, 1'b1);
        e.e1 = model(x, y, act_m, 0, 1'b0);
        e.e2 = model(x, y, act_m, 2, 1'b1);
        e.v = v;
        q.push_back(e);
        tick();
        nact = fs ? sh_m : act_m;
        if (ld) sh_m = d;
        act_m = nact;
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("rnd_s1", 32'(data0), 32'(e.e0));
            chk("rnd_s0", 32'(data1), 32'(e.e1));
            chk("rnd_s2", 32'(data2), 32'(e.e2));
            chk("rnd_vld", 32'(dv0), 32'(e.v));
        end
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{64, 48, BG, "org_row0"};
        vt[1]  = '{82, 54, FG, "d1_f_r3"};
        vt[2]  = '{66, 52, BG, "d0_blank_f"};
        vt[3]  = '{76, 60, BG, "d0_blank_b"};
        vt[4]  = '{98, 62, FG, "d2_g_r7"};
        vt[5]  = '{98, 64, FG, "d2_g_r8"};
        vt[6]  = '{108, 62, FG, "d2_c"};
        vt[7]  = '{86, 50, BG, "d1_no_a"};
        vt[8]  = '{108, 52, BG, "d2_no_b"};
        vt[9]  = '{40, 40, BG, "outside"};
        vt[10] = '{112, 60, BG, "right_of_box"};
        vt[11] = '{80, 52, BG, "d1_col0"};

        repeat (2) tick();
        chk("rst_data", 32'(data0), 32'(BG));
        chk("rst_vld", 32'(dv0), 32'd0);
        chk("rst_data_s0", 32'(data1), 32'(BG));
        chk("rst_data_s2", 32'(data2), 32'(BG));
        reset = 1'b0;
        tick();

        probe(82, 54);
        chk("blank_after_rst", 32'(data0), 32'(BG));

        load(12'h045, 1'b0);
        fstart();
        foreach (vt[i]) begin
            probe(vt[i].x, vt[i].y);
            chk(vt[i].nm, 32'(data0), 32'(vt[i].exp));
        end
        probe(92, 72);
        chk("d1_c", 32'(data0), 32'(FG));

        load(12'h888, 1'b0);
        probe(66, 50);
        chk("888_no_fs", 32'(data0), 32'(BG));
        fstart();
        probe(66, 50);
        chk("888_d0", 32'(data0), 32'(FG));
        probe(102, 62);
        chk("888_d2_g", 32'(data0), 32'(FG));

        load(12'h111, 1'b1);
        probe(86, 50);
        chk("same_cyc_old", 32'(data0), 32'(FG));
        fstart();
        probe(86, 50);
        chk("same_cyc_new_a", 32'(data0), 32'(BG));
        probe(92, 52);
        chk("same_cyc_new_b", 32'(data0), 32'(FG));

        load(12'h000, 1'b0);
        fstart();
        probe(65, 51);
        chk("bl0_d0", 32'(data1), 32'(FG));
        probe(73, 51);
        chk("bl0_d1", 32'(data1), 32'(FG));
        probe(66, 54);
        chk("bl1_d0", 32'(data0), 32'(BG));
        probe(98, 54);
        chk("bl1_d2", 32'(data0), 32'(FG));
        probe(68, 60);
        chk("s2_bl1_d0", 32'(data2), 32'(BG));
        probe(132, 60);
        chk("s2_bl1_d2", 32'(data2), 32'(FG));

        load(12'hABC, 1'b0);
        fstart();
        probe(66, 50);
        chk("code_hi_a", 32'(data0), 32'(BG));
        probe(98, 62);
        chk("code_hi_g", 32'(data0), 32'(BG));

        pix_valid = 1'b0;
        repeat (4) tick();
        for (int c = 0; c < 10; c++) begin
            pix_valid = (c < 5);
            tick();
            chk($sformatf("burst_c%0d", c + 1), 32'(dv0),
                32'((c + 1 >= 3) && (c + 1 <= 7)));
        end

        load(12'h045, 1'b0);
        fstart();
        pix_valid = 1'b0;
        repeat (4) tick();
        hcount = 10'd82;
        vcount = 10'd54;
        pix_valid = 1'b1;
        repeat (4) tick();
        chk("pre_rst_vld", 32'(dv0), 32'd1);
        chk("pre_rst_data", 32'(data0), 32'(FG));
        reset = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(dv0), 32'd0);
        chk("mid_rst_data", 32'(data0), 32'(BG));
        tick();
        reset = 1'b0;
        probe(82, 54);
        chk("post_rst_blank", 32'(data0), 32'(BG));

        load(12'h444, 1'b0);
        fstart();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                probe(72 + c, 48 + r);
                chk($sformatf("leg4_s0_c%0d_r%0d", c, r), 32'(data1),
                    legacy4(c, r) ? 32'(FG) : 32'(BG));
                probe(96 + 4 * c + $urandom_range(0, 3),
                      48 + 4 * r + $urandom_range(0, 3));
                chk($sformatf("leg4_s2_c%0d_r%0d", c, r), 32'(data2),
                    legacy4(c, r) ? 32'(FG) : 32'(BG));
            end
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        sh_m = 12'hFFF;
        act_m = 12'hFFF;
        q.delete();
        for (int n = 0; n < 4000; n++) begin
            logic [11:0] d;
            for (int k = 0; k < 3; k++) begin
                d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0
                            : 4'($urandom_range(0, 15));
            end
            apply($urandom_range(40, 200), $urandom_range(30, 130),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  d, $urandom_range(0, 49) == 0);
        end
        digits_load = 1'b0;
        frame_start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
